// File: rtl/cnn_pkg.sv
// cnn_pkg: shared layer-memory select codes, map dimensions and stream FSM states
package cnn_pkg;
  localparam logic [2:0] L0_SEL = 3'b001;
  localparam logic [2:0] L1_SEL = 3'b011;
  localparam int IMG_W = 64;
  localparam int L1_W = 32;
  localparam int NPIX_L1 = L1_W * L1_W;
  localparam int DATA_W = 20;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two depth FIFO; push into a full FIFO is accepted only alongside a pop
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (PW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // head reads as zero when empty so the stream data output is clean after reset
  assign rdata = empty ? '0 : mem[rp];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + PW'(1);
      if (do_pop) rp <= rp + PW'(1);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;
endmodule

// File: rtl/l1_stream_out.sv
// l1_stream_out: streams the 32x32 layer-1 map from layer memory over valid/ready,
// tracking a frame checksum and maximum
module l1_stream_out #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int NPIX = cnn_pkg::NPIX_L1,
  parameter logic [2:0] L1_SEL = cnn_pkg::L1_SEL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              crd,
  output logic [11:0]       caddr_rd,
  output logic [2:0]        csel,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [9:0]        m_index,
  output logic              m_last,
  output logic              done,
  output logic [29:0]       checksum,
  output logic [DATA_W-1:0] max_val
);
  import cnn_pkg::*;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [9:0] LAST = 10'(NPIX - 1);
  state_t state, state_n;
  logic [9:0] rd_addr;
  logic inflight, pop, last_pop, empty, full;
  logic [CW-1:0] count;
  logic [CW:0] occ;
  sync_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_fifo (
    .clk(clk), .reset(reset), .push(inflight), .wdata(cdata_rd), .pop(pop),
    .rdata(m_data), .count(count), .full(full), .empty(empty)
  );
  assign m_valid = !empty;
  assign pop = m_valid && m_ready;
  assign m_last = m_valid && m_index == LAST;
  assign last_pop = pop && m_last;
  assign caddr_rd = 12'(rd_addr);
  // occupancy the FIFO will have once this cycle's pop and the in-flight read land
  assign occ = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  always_comb begin
    crd = 1'b0;
    done = 1'b0;
    state_n = state;
    crd = state == RUN && (!full || pop) && occ < (CW+1)'(FIFO_DEPTH);
    done = state == DONE;
    state_n = state == IDLE  ? (start ? RUN : IDLE)
            : state == RUN   ? (crd && rd_addr == LAST ? DRAIN : RUN)
            : state == DRAIN ? (last_pop ? DONE : DRAIN)
            : IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      busy <= 1'b0;
      csel <= '0;
      rd_addr <= '0;
      inflight <= 1'b0;
      m_index <= '0;
      checksum <= '0;
      max_val <= '0;
    end else begin
      inflight <= crd;
      if (state == IDLE && start) begin
        busy <= 1'b1;
        csel <= L1_SEL;
        rd_addr <= '0;
        m_index <= '0;
        checksum <= '0;
        max_val <= '0;
      end else begin
        if (crd && rd_addr != LAST) rd_addr <= rd_addr + 10'd1;
        if (pop) begin
          m_index <= m_index + 10'd1;
          checksum <= checksum + 30'(m_data);
          max_val <= m_data > max_val ? m_data : max_val;
        end
        if (last_pop) busy <= 1'b0;
      end
    end
endmodule

// File: tb/tb_l1_stream_out.sv
// tb_l1_stream_out: directed frame-streaming scenarios against a layer-memory model
module tb_l1_stream_out;
  localparam int NPIX = 1024;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset, start, m_ready;
  logic [19:0] cdata_rd;
  logic busy, crd, m_valid, m_last, done;
  logic [11:0] caddr_rd;
  logic [2:0] csel;
  logic [19:0] m_data, max_val;
  logic [9:0] m_index;
  logic [29:0] checksum;
  logic [99:0] outs;
  logic [19:0] mem [NPIX];
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  l1_stream_out dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .crd(crd), .caddr_rd(caddr_rd),
    .csel(csel), .cdata_rd(cdata_rd), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_index(m_index), .m_last(m_last), .done(done), .checksum(checksum), .max_val(max_val)
  );
  assign outs = {crd, caddr_rd, csel, busy, m_valid, m_data, m_index, m_last, done, checksum, max_val};
  always @(posedge clk)
    cdata_rd <= (crd && csel == 3'b011) ? mem[caddr_rd[9:0]] : 20'h0;
  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (outs !== '0) begin fails++; $display("FAIL reset_outputs: got %h want 0", outs); end
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || crd !== 1'b0) begin
      fails++; $display("FAIL reset_idle: busy=%b done=%b crd=%b want 0 0 0", busy, done, crd);
    end
  endtask
  task automatic start_frame();
    @(negedge clk);
    start = 1'b1;
    m_ready = 1'b0;
    #1;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL pre_start: done=%b busy=%b want 0 0", done, busy);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    tests++;
    if (busy !== 1'b1 || checksum !== 30'd0 || max_val !== 20'd0 || csel !== 3'b011) begin
      fails++;
      $display("FAIL start_clear: busy=%b sum=%0d max=%0d csel=%b want 1 0 0 011", busy, checksum, max_val, csel);
    end
  endtask
  // mode 0: ready high, 1: LFSR ready, 2: ready low 20 cycles, 3: restart at beat 300, 4: reset at beat 500
  task automatic test_stream(input string name, input int mode, input logic [29:0] exp_sum, input logic [19:0] exp_max);
    int idx, issued, ncyc, first_valid, reads_at_pop, pop_cyc;
    logic stall, pop;
    logic [19:0] pdata;
    logic [9:0] pidx;
    logic [15:0] lfsr;
    lfsr = 16'hACE1;
    start_frame();
    idx = 0; issued = 0; ncyc = 0; first_valid = -1; reads_at_pop = -1; pop_cyc = -1; stall = 1'b0;
    pdata = '0; pidx = '0;
    while (idx < NPIX && ncyc < 6000) begin
      @(negedge clk);
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      m_ready = mode == 1 ? lfsr[0] : mode == 2 ? (ncyc >= 20) : 1'b1;
      start = mode == 3 && idx == 300;
      if (mode == 4 && idx == 500) begin
        reset = 1'b0;
        #1;
        tests++;
        if (outs !== '0) begin fails++; $display("FAIL %s async_reset: got %h want 0", name, outs); end
        repeat (3) begin
          @(negedge clk);
          tests++;
          if (done !== 1'b0 || busy !== 1'b0 || crd !== 1'b0) begin
            fails++; $display("FAIL %s in_reset: done=%b busy=%b crd=%b want 0 0 0", name, done, busy, crd);
          end
        end
        reset = 1'b1;
        repeat (3) begin
          @(negedge clk);
          tests++;
          if (done !== 1'b0 || busy !== 1'b0 || crd !== 1'b0 || m_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s post_reset_idle: done=%b busy=%b crd=%b valid=%b want 0 0 0 0", name, done, busy, crd, m_valid);
          end
        end
        return;
      end
      #1;
      pop = m_valid && m_ready;
      if (first_valid < 0 && m_valid) first_valid = ncyc;
      tests++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        fails++; $display("FAIL %s busy_run cyc %0d: busy=%b done=%b want 1 0", name, ncyc, busy, done);
      end
      if (stall) begin
        tests++;
        if (m_valid !== 1'b1 || m_data !== pdata || m_index !== pidx) begin
          fails++;
          $display("FAIL %s stall_stable cyc %0d: valid=%b data=%0d idx=%0d want 1 %0d %0d", name, ncyc, m_valid, m_data, m_index, pdata, pidx);
        end
      end
      if (pop && reads_at_pop < 0) begin reads_at_pop = issued; pop_cyc = ncyc; end
      if (crd) begin
        tests++;
        if (caddr_rd !== 12'(issued) || issued - idx - int'(pop) >= DEPTH) begin
          fails++;
          $display("FAIL %s read cyc %0d: addr=%0d occ=%0d want addr %0d occ<%0d", name, ncyc, caddr_rd, issued - idx - int'(pop), issued, DEPTH);
        end
        issued++;
      end
      if (pop) begin
        tests++;
        if (m_data !== mem[idx] || m_index !== 10'(idx) || m_last !== (idx == NPIX - 1)) begin
          fails++;
          $display("FAIL %s beat %0d: data=%0d idx=%0d last=%b want %0d %0d %b", name, idx, m_data, m_index, m_last, mem[idx], idx, idx == NPIX - 1);
        end
        idx++;
      end
      stall = m_valid && !m_ready;
      pdata = m_data;
      pidx = m_index;
      ncyc++;
    end
    start = 1'b0;
    tests++;
    if (idx < NPIX) begin fails++; $display("FAIL %s timeout: beats=%0d want %0d", name, idx, NPIX); end
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0 || crd !== 1'b0) begin
      fails++; $display("FAIL %s done: done=%b busy=%b valid=%b crd=%b want 1 0 0 0", name, done, busy, m_valid, crd);
    end
    tests++;
    if (checksum !== exp_sum || max_val !== exp_max) begin
      fails++; $display("FAIL %s result: sum=%0d max=%0d want %0d %0d", name, checksum, max_val, exp_sum, exp_max);
    end
    if (mode == 0) begin
      tests++;
      if (first_valid !== 2 || ncyc !== 1026) begin
        fails++; $display("FAIL %s latency: first_valid=%0d done_at=%0d want 2 1026", name, first_valid, ncyc);
      end
    end
    if (mode == 2) begin
      tests++;
      if (reads_at_pop !== DEPTH || pop_cyc !== 20) begin
        fails++; $display("FAIL %s stall_reads: reads=%0d first_pop=%0d want %0d 20", name, reads_at_pop, pop_cyc, DEPTH);
      end
    end
  endtask
  initial begin
    for (int a = 0; a < NPIX; a++) mem[a] = 20'(a * 3);
    test_reset();
    test_stream("ready_high", 0, 30'd1571328, 20'd3069);
    test_stream("lfsr_ready", 1, 30'd1571328, 20'd3069);
    test_stream("stall20", 2, 30'd1571328, 20'd3069);
    test_stream("restart_ignored", 3, 30'd1571328, 20'd3069);
    test_stream("start_after_done", 0, 30'd1571328, 20'd3069);
    for (int a = 0; a < NPIX; a++) mem[a] = 20'h0;
    mem[517] = 20'hFFFFF;
    test_stream("peak", 0, 30'd1048575, 20'hFFFFF);
    for (int a = 0; a < NPIX; a++) mem[a] = 20'(a * 3);
    test_stream("abort", 4, 30'd0, 20'd0);
    test_stream("after_abort", 0, 30'd1571328, 20'd3069);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
